// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// registered operand stage, a capture stage and a per-port response slot.
module alu_share_arbiter #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [1:0]        req0_aluop,
   input  logic [3:0]        req0_cmd,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [TAG_W-1:0]  req0_tag,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [1:0]        req1_aluop,
   input  logic [3:0]        req1_cmd,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [TAG_W-1:0]  req1_tag,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_flag,
   output logic [TAG_W-1:0]  rsp0_tag,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_flag,
   output logic [TAG_W-1:0]  rsp1_tag,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [1:0]        alu_aluop,
   output logic [3:0]        alu_cmd,
   input  logic [DATA_W-1:0] alu_result
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_INFLIGHT = 2'd1,
      ST_FULL     = 2'd2
   } port_st_t;

   port_st_t           st0_r, st1_r;
   logic               rr_ptr_r;
   logic               cap_valid_r;
   logic               cap_owner_r;
   logic [1:0]         cap_aluop_r;
   logic [TAG_W-1:0]   cap_tag_r;

   logic               elig0_s, elig1_s;
   logic               accept0_s, accept1_s;
   logic [DATA_W-1:0]  cap_result_s;
   logic               cap_flag_s;

   // Zero flag only qualifies subtract/compare operations
   function automatic logic zero_flag(input logic [1:0] aluop, input logic [DATA_W-1:0] res);
      return (aluop == 2'd1) && (res == {DATA_W{1'b0}});
   endfunction

   // Grant, handshake decode and capture-stage result shaping
   always_comb begin
      elig0_s    = (st0_r == ST_IDLE) && !reset;
      elig1_s    = (st1_r == ST_IDLE) && !reset;
      req0_ready = elig0_s && (!(req1_valid && elig1_s) || (rr_ptr_r == 1'b0));
      req1_ready = elig1_s && (!(req0_valid && elig0_s) || (rr_ptr_r == 1'b1));
      accept0_s  = req0_valid && req0_ready;
      accept1_s  = req1_valid && req1_ready;
      rsp0_valid = (st0_r == ST_FULL);
      rsp1_valid = (st1_r == ST_FULL);
      // Illegal ops are carried through the pipe but their ALU output is discarded
      if (cap_aluop_r == 2'd3) begin
         cap_result_s = {DATA_W{1'b0}};
      end else begin
         cap_result_s = alu_result;
      end
      cap_flag_s = zero_flag(cap_aluop_r, cap_result_s);
   end

   // Operand stage, capture stage, response slots and per-port state
   always_ff @(posedge clk) begin
      if (reset) begin
         st0_r       <= ST_IDLE;
         st1_r       <= ST_IDLE;
         rr_ptr_r    <= 1'b0;
         cap_valid_r <= 1'b0;
         cap_owner_r <= 1'b0;
         cap_aluop_r <= 2'd0;
         cap_tag_r   <= {TAG_W{1'b0}};
         alu_in1     <= {DATA_W{1'b0}};
         alu_in2     <= {DATA_W{1'b0}};
         alu_aluop   <= 2'd0;
         alu_cmd     <= 4'd0;
         rsp0_result <= {DATA_W{1'b0}};
         rsp0_flag   <= 1'b0;
         rsp0_tag    <= {TAG_W{1'b0}};
         rsp1_result <= {DATA_W{1'b0}};
         rsp1_flag   <= 1'b0;
         rsp1_tag    <= {TAG_W{1'b0}};
      end else begin
         cap_valid_r <= accept0_s || accept1_s;
         if (accept0_s) begin
            alu_in1     <= req0_a;
            alu_in2     <= req0_b;
            alu_aluop   <= req0_aluop;
            alu_cmd     <= req0_cmd;
            cap_owner_r <= 1'b0;
            cap_aluop_r <= req0_aluop;
            cap_tag_r   <= req0_tag;
            rr_ptr_r    <= 1'b1;
         end else if (accept1_s) begin
            alu_in1     <= req1_a;
            alu_in2     <= req1_b;
            alu_aluop   <= req1_aluop;
            alu_cmd     <= req1_cmd;
            cap_owner_r <= 1'b1;
            cap_aluop_r <= req1_aluop;
            cap_tag_r   <= req1_tag;
            rr_ptr_r    <= 1'b0;
         end else begin
            cap_owner_r <= cap_owner_r;
         end

         if (cap_valid_r && (cap_owner_r == 1'b0)) begin
            rsp0_result <= cap_result_s;
            rsp0_flag   <= cap_flag_s;
            rsp0_tag    <= cap_tag_r;
         end else if (cap_valid_r) begin
            rsp1_result <= cap_result_s;
            rsp1_flag   <= cap_flag_s;
            rsp1_tag    <= cap_tag_r;
         end else begin
            rsp0_tag <= rsp0_tag;
         end

         case (st0_r)
            ST_IDLE:     if (accept0_s) st0_r <= ST_INFLIGHT;
            ST_INFLIGHT: if (cap_valid_r && (cap_owner_r == 1'b0)) st0_r <= ST_FULL;
            ST_FULL:     if (rsp0_ready) st0_r <= ST_IDLE;
            default:     st0_r <= ST_IDLE;
         endcase

         case (st1_r)
            ST_IDLE:     if (accept1_s) st1_r <= ST_INFLIGHT;
            ST_INFLIGHT: if (cap_valid_r && (cap_owner_r == 1'b1)) st1_r <= ST_FULL;
            ST_FULL:     if (rsp1_ready) st1_r <= ST_IDLE;
            default:     st1_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter; the bench also plays the shared ALU and
// tracks each port as at most one outstanding operation with its accept cycle.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        v[2];
   logic        ready[2];
   logic [1:0]  op[2];
   logic [3:0]  cmd[2];
   logic [31:0] a[2];
   logic [31:0] b[2];
   logic [3:0]  tg[2];
   logic        rv[2];
   logic        rrdy[2];
   logic [31:0] res[2];
   logic        fl[2];
   logic [3:0]  rtag[2];
   logic [31:0] alu_in1, alu_in2, alu_result;
   logic [1:0]  alu_aluop;
   logic [3:0]  alu_cmd;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] res;
      logic        flag;
      logic [3:0]  tag;
      int          acc;
   } rsp_t;

   bit          has[2];
   rsp_t        slot[2];
   int          rr;
   int          cyc;
   logic [31:0] last_a, last_b;
   logic [5:0]  last_ctl;

   always #5 clk = ~clk;

   alu_share_arbiter #(.DATA_W(32), .TAG_W(4)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(v[0]), .req0_ready(ready[0]), .req0_aluop(op[0]), .req0_cmd(cmd[0]),
      .req0_a(a[0]), .req0_b(b[0]), .req0_tag(tg[0]),
      .req1_valid(v[1]), .req1_ready(ready[1]), .req1_aluop(op[1]), .req1_cmd(cmd[1]),
      .req1_a(a[1]), .req1_b(b[1]), .req1_tag(tg[1]),
      .rsp0_valid(rv[0]), .rsp0_ready(rrdy[0]), .rsp0_result(res[0]), .rsp0_flag(fl[0]),
      .rsp0_tag(rtag[0]),
      .rsp1_valid(rv[1]), .rsp1_ready(rrdy[1]), .rsp1_result(res[1]), .rsp1_flag(fl[1]),
      .rsp1_tag(rtag[1]),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_aluop(alu_aluop), .alu_cmd(alu_cmd),
      .alu_result(alu_result)
   );

   function automatic logic [31:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                           input logic [1:0] o, input logic [3:0] c);
      logic [31:0] r;
      case (o)
         2'd0: r = x + y;
         2'd1: r = x - y;
         2'd2: case (c)
            4'd0: r = x + y;
            4'd1: r = x - y;
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = x << y[4:0];
            4'd6: r = x >> y[4:0];
            4'd7: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd8: r = (x < y) ? 32'd1 : 32'd0;
            4'd9: r = $unsigned($signed(x) >>> y[4:0]);
            default: r = 32'd0;
         endcase
         default: r = 32'hDEAD_BEEF;
      endcase
      return r;
   endfunction

   assign alu_result = alu_ref(alu_in1, alu_in2, alu_aluop, alu_cmd);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: check outputs against the model, advance the model across the edge.
   task automatic step();
      bit   el[2];
      logic exp_rdy[2];
      bit   exp_rv[2];
      #1;
      for (int p = 0; p < 2; p++) el[p] = !has[p] && !reset;
      for (int p = 0; p < 2; p++) begin
         exp_rdy[p] = el[p] && (!(v[1-p] && el[1-p]) || rr == p);
         exp_rv[p]  = has[p] && (cyc >= slot[p].acc + 2);
         check($sformatf("req%0d_ready", p), {31'd0, ready[p]}, {31'd0, exp_rdy[p]});
         check($sformatf("rsp%0d_valid", p), {31'd0, rv[p]}, {31'd0, exp_rv[p]});
         if (exp_rv[p]) begin
            check($sformatf("rsp%0d_result", p), res[p], slot[p].res);
            check($sformatf("rsp%0d_flag", p), {31'd0, fl[p]}, {31'd0, slot[p].flag});
            check($sformatf("rsp%0d_tag", p), {28'd0, rtag[p]}, {28'd0, slot[p].tag});
         end
      end
      check("alu_in1", alu_in1, last_a);
      check("alu_in2", alu_in2, last_b);
      check("alu_ctl", {26'd0, alu_aluop, alu_cmd}, {26'd0, last_ctl});
      @(posedge clk);
      if (reset) begin
         has[0] = 1'b0; has[1] = 1'b0; rr = 0;
         last_a = 32'd0; last_b = 32'd0; last_ctl = 6'd0;
      end else begin
         for (int p = 0; p < 2; p++)
            if (exp_rv[p] && rrdy[p]) has[p] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            if (v[p] && exp_rdy[p]) begin
               has[p]       = 1'b1;
               slot[p].res  = (op[p] == 2'd3) ? 32'd0 : alu_ref(a[p], b[p], op[p], cmd[p]);
               slot[p].flag = (op[p] == 2'd1) && (slot[p].res == 32'd0);
               slot[p].tag  = tg[p];
               slot[p].acc  = cyc;
               last_a = a[p]; last_b = b[p]; last_ctl = {op[p], cmd[p]};
               rr = 1 - p;
            end
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic rand_req(input int p);
      op[p]  = 2'($urandom_range(0, 3));
      cmd[p] = 4'($urandom_range(0, 10));
      a[p]   = ($urandom_range(0, 3) == 0) ? 32'h0000_1234 : $urandom;
      b[p]   = ($urandom_range(0, 3) == 0) ? 32'h0000_1234 : $urandom;
      tg[p]  = 4'($urandom);
   endtask

   // Present one op on port p for a single cycle, then idle until its response shows.
   task automatic issue(input int p, input logic [1:0] o, input logic [3:0] c,
                        input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
      op[p] = o; cmd[p] = c; a[p] = x; b[p] = y; tg[p] = t; v[p] = 1'b1;
      step();
      v[p] = 1'b0;
      step();
      step();
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         v[p] = 1'b0; rrdy[p] = 1'b1; op[p] = 2'd0; cmd[p] = 4'd0;
         a[p] = 32'd0; b[p] = 32'd0; tg[p] = 4'd0; has[p] = 1'b0;
      end
      cyc = 0; rr = 0; last_a = 32'd0; last_b = 32'd0; last_ctl = 6'd0;
      reset = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      v[0] = 1'b1; v[1] = 1'b1;
      step();
      reset = 1'b0; v[0] = 1'b0; v[1] = 1'b0;
      check("reset_result0", res[0], 32'd0);
      check("reset_tag1", {28'd0, rtag[1]}, 32'd0);

      // Basic add with latency 2, then consumption
      issue(0, 2'd0, 4'd0, 32'd5, 32'd7, 4'd3);
      check("add_result", res[0], 32'd12);
      check("add_tag", {28'd0, rtag[0]}, 32'd3);
      step();
      check("add_consumed", {31'd0, rv[0]}, 32'd0);

      issue(1, 2'd1, 4'd0, 32'h1234, 32'h1234, 4'd1);
      check("cmp_eq_flag", {31'd0, fl[1]}, 32'd1);
      step();
      issue(1, 2'd1, 4'd0, 32'd9, 32'd4, 4'd2);
      check("cmp_ne_result", res[1], 32'd5);
      step();
      issue(1, 2'd2, 4'd1, 32'h55, 32'h55, 4'd4);
      check("rtype_sub_flag", {31'd0, fl[1]}, 32'd0);
      step();
      issue(0, 2'd3, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd9);
      check("illegal_result", res[0], 32'd0);
      step();

      // Both ports streaming, responses always taken
      v[0] = 1'b1; v[1] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         rand_req(0); rand_req(1); step();
      end
      // Port 0 back-pressured for 10 cycles
      rrdy[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rand_req(1); step();
      end
      rrdy[0] = 1'b1;
      v[0] = 1'b0; v[1] = 1'b0;
      step(); step(); step();

      // Reset the cycle after an accept, then a clean op
      issue(0, 2'd0, 4'd0, 32'd1, 32'd2, 4'd5);
      v[0] = 1'b1; op[0] = 2'd0; a[0] = 32'd40; b[0] = 32'd2; tg[0] = 4'd6;
      step();
      v[0] = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      step(); step();
      issue(0, 2'd0, 4'd0, 32'd100, 32'd23, 4'd7);
      check("post_reset_result", res[0], 32'd123);
      step();

      // Random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         for (int p = 0; p < 2; p++) begin
            v[p]    = ($urandom_range(0, 3) != 0);
            rrdy[p] = ($urandom_range(0, 3) != 0);
            rand_req(p);
         end
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
